mandelbrot_core_scheduler: RTL and testbench

- Sequences one Mandelbrot frame across CORE_NUM iteration cores.
- Walks the W×H pixel grid in raster order and computes c_re/c_im incrementally.
- Dispatches each pixel job to a free core in round-robin order, then arbitrates core results onto the single frame-buffer write port.
- Sits between the parameter/key state machine (start, center, scale, max_iter) and the frame buffer write side.

---
 rtl/mandelbrot_core_scheduler.sv | 279 +++++++++++++++++++++++++++
 tb/tb_mandelbrot_core_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_core_scheduler.sv
// mandelbrot_core_scheduler
// Sequences one Mandelbrot frame over CORE_NUM iteration cores. Pixels are
// walked in raster order with c_re/c_im stepped incrementally, each pixel job
// is offered to a free core in round-robin order, and core results are
// arbitrated (separate round-robin pointer) onto the single frame-buffer write
// port.
// Ports:
//   clk, rst_n                 core clock, asynchronous active-low reset
//   start                      single-cycle frame request
//   center_re/center_im/scale  signed fixed-point frame parameters
//   max_iter                   iteration limit forwarded on job_max_iter
//   job_valid/job_ready        one-hot job offer / per-core accept
//   job_re/job_im/job_addr     shared job payload
//   res_valid/res_iter/res_addr/res_ack  per-core result handshake
//   wr_addr/wr_data/wr_en      frame buffer write side
//   busy, done                 frame in progress, frame-complete pulse
module mandelbrot_core_scheduler #(
  parameter int W        = 600,
  parameter int H        = 400,
  parameter int ADDR_W   = 19,
  parameter int CORE_NUM = 8,
  parameter int FP_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic signed [FP_W-1:0]       center_re,
  input  logic signed [FP_W-1:0]       center_im,
  input  logic signed [FP_W-1:0]       scale,
  input  logic [7:0]                   max_iter,
  output logic [CORE_NUM-1:0]          job_valid,
  input  logic [CORE_NUM-1:0]          job_ready,
  output logic signed [FP_W-1:0]       job_re,
  output logic signed [FP_W-1:0]       job_im,
  output logic [ADDR_W-1:0]            job_addr,
  output logic [7:0]                   job_max_iter,
  input  logic [CORE_NUM-1:0]          res_valid,
  input  logic [8*CORE_NUM-1:0]        res_iter,
  input  logic [ADDR_W*CORE_NUM-1:0]   res_addr,
  output logic [CORE_NUM-1:0]          res_ack,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [7:0]                   wr_data,
  output logic                         wr_en,
  output logic                         busy,
  output logic                         done
);

  localparam int IDX_W = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;
  localparam int X_W   = (W > 1) ? $clog2(W) : 1;
  localparam int Y_W   = (H > 1) ? $clog2(H) : 1;
  localparam int TOTAL = W * H;
  localparam int CNT_W = $clog2(TOTAL + 1);

  localparam logic [CNT_W-1:0]       TOTAL_C    = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0]       LAST_JOB_C = CNT_W'(TOTAL - 1);
  localparam logic [X_W-1:0]         X_MAX_C    = X_W'(W - 1);
  localparam logic [Y_W-1:0]         Y_MAX_C    = Y_W'(H - 1);
  localparam logic [ADDR_W-1:0]      W_C        = ADDR_W'(W);
  localparam logic signed [FP_W-1:0] HALF_W_C   = FP_W'(W / 2);
  localparam logic signed [FP_W-1:0] HALF_H_C   = FP_W'(H / 2);
  localparam logic [IDX_W-1:0]       IDX_MAX_C  = IDX_W'(CORE_NUM - 1);
  localparam logic [CORE_NUM-1:0]    ONE_HOT_C  = {{(CORE_NUM-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_DISPATCH = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // First requester at or above ptr (with wrap); MSB flags that one was found.
  function automatic logic [IDX_W:0] rr_pick(input logic [CORE_NUM-1:0] req,
                                             input logic [IDX_W-1:0]    ptr);
    logic [IDX_W:0]   pick;
    logic [IDX_W-1:0] jj;
    int               j;
    pick = '0;
    // Scan farthest-first so the nearest requester overwrites the result.
    for (int i = CORE_NUM - 1; i >= 0; i--) begin
      j  = (int'(ptr) + i >= CORE_NUM) ? (int'(ptr) + i - CORE_NUM) : (int'(ptr) + i);
      jj = IDX_W'(j);
      if (req[jj]) pick = {1'b1, jj};
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_MAX_C) ? '0 : idx + 1'b1;
  endfunction

  state_t                  state_r, state_next_s;
  logic signed [FP_W-1:0]  lat_re_r, lat_im_r, scale_r;
  logic [7:0]              max_iter_r;
  logic signed [FP_W-1:0]  row_re0_r, cur_re_r, cur_im_r;
  logic signed [FP_W-1:0]  setup_re0_s, setup_im_s;
  logic [X_W-1:0]          x_r;
  logic [Y_W-1:0]          y_r;
  logic [CNT_W-1:0]        disp_cnt_r, wr_cnt_r;
  logic [IDX_W-1:0]        job_rr_r, res_rr_r, job_idx_r;
  logic                    pending_r;
  logic [CORE_NUM-1:0]     job_valid_r, res_ack_r;
  logic signed [FP_W-1:0]  job_re_r, job_im_r;
  logic [ADDR_W-1:0]       job_addr_r, wr_addr_r;
  logic [7:0]              wr_data_r;
  logic                    wr_en_r, busy_r, done_r;
  logic                    busy_next_s, done_next_s, latch_s, arb_en_s, xfer_s;
  logic [IDX_W:0]          job_pick_s, arb_pick_s;
  logic [CORE_NUM-1:0]     arb_oh_s;
  logic [ADDR_W-1:0]       sel_addr_s;
  logic [7:0]              sel_iter_s;

  assign job_valid    = job_valid_r;
  assign job_re       = job_re_r;
  assign job_im       = job_im_r;
  assign job_addr     = job_addr_r;
  assign job_max_iter = max_iter_r;
  assign res_ack      = res_ack_r;
  assign wr_addr      = wr_addr_r;
  assign wr_data      = wr_data_r;
  assign wr_en        = wr_en_r;
  assign busy         = busy_r;
  assign done         = done_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:     if (start) state_next_s = ST_SETUP; else state_next_s = ST_IDLE;
      ST_SETUP:    state_next_s = ST_DISPATCH;
      ST_DISPATCH: if (xfer_s && (disp_cnt_r == LAST_JOB_C)) state_next_s = ST_DRAIN;
                   else state_next_s = ST_DISPATCH;
      ST_DRAIN:    if (wr_cnt_r == TOTAL_C) state_next_s = ST_DRAIN == ST_DRAIN ? ST_DONE : ST_DRAIN;
                   else state_next_s = ST_DRAIN;
      ST_DONE:     if (pending_r || start) state_next_s = ST_SETUP; else state_next_s = ST_IDLE;
      default:     state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs; busy/done are registered from the next state
  always_comb begin
    busy_next_s = (state_next_s == ST_SETUP) || (state_next_s == ST_DISPATCH) ||
                  (state_next_s == ST_DRAIN);
    done_next_s = (state_next_s == ST_DONE);
    // A rerun out of DONE samples the inputs present at that moment.
    latch_s     = ((state_r == ST_IDLE) && start) ||
                  ((state_r == ST_DONE) && (pending_r || start));
    arb_en_s    = (state_r == ST_DISPATCH) || (state_r == ST_DRAIN);
  end

  // Handshake decode, round-robin picks and result mux
  always_comb begin
    xfer_s      = |(job_valid_r & job_ready);
    job_pick_s  = rr_pick(job_ready, job_rr_r);
    // A core still sees its ack this cycle, so exclude it to avoid a double write.
    arb_pick_s  = rr_pick(res_valid & ~res_ack_r, res_rr_r);
    arb_oh_s    = arb_pick_s[IDX_W] ? (ONE_HOT_C << arb_pick_s[IDX_W-1:0]) : '0;
    setup_re0_s = lat_re_r - scale_r * HALF_W_C;
    setup_im_s  = lat_im_r + scale_r * HALF_H_C;
    sel_addr_s  = '0;
    sel_iter_s  = 8'd0;
    for (int i = 0; i < CORE_NUM; i++) begin
      sel_addr_s = sel_addr_s | (res_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{arb_oh_s[i]}});
      sel_iter_s = sel_iter_s | (res_iter[i*8 +: 8] & {8{arb_oh_s[i]}});
    end
  end

  // Frame parameter capture, frozen for the frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_re_r   <= '0;
      lat_im_r   <= '0;
      scale_r    <= '0;
      max_iter_r <= 8'd0;
    end else if (latch_s) begin
      lat_re_r   <= center_re;
      lat_im_r   <= center_im;
      scale_r    <= scale;
      max_iter_r <= max_iter;
    end
  end

  // Pixel walk and job offer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_re0_r   <= '0;
      cur_re_r    <= '0;
      cur_im_r    <= '0;
      x_r         <= '0;
      y_r         <= '0;
      disp_cnt_r  <= '0;
      job_rr_r    <= '0;
      job_idx_r   <= '0;
      job_valid_r <= '0;
      job_re_r    <= '0;
      job_im_r    <= '0;
      job_addr_r  <= '0;
    end else if (state_r == ST_SETUP) begin
      row_re0_r   <= setup_re0_s;
      cur_re_r    <= setup_re0_s;
      cur_im_r    <= setup_im_s;
      x_r         <= '0;
      y_r         <= '0;
      disp_cnt_r  <= '0;
      job_valid_r <= '0;
    end else if (state_r == ST_DISPATCH) begin
      if (xfer_s) begin
        job_valid_r <= '0;
        job_rr_r    <= idx_inc(job_idx_r);
        disp_cnt_r  <= disp_cnt_r + 1'b1;
        if (x_r == X_MAX_C) begin
          x_r      <= '0;
          y_r      <= (y_r == Y_MAX_C) ? '0 : y_r + 1'b1;
          cur_re_r <= row_re0_r;
          cur_im_r <= cur_im_r - scale_r;
        end else begin
          x_r      <= x_r + 1'b1;
          cur_re_r <= cur_re_r + scale_r;
        end
      end else if ((job_valid_r == '0) && job_pick_s[IDX_W]) begin
        job_valid_r <= ONE_HOT_C << job_pick_s[IDX_W-1:0];
        job_idx_r   <= job_pick_s[IDX_W-1:0];
        job_re_r    <= cur_re_r;
        job_im_r    <= cur_im_r;
        job_addr_r  <= ADDR_W'(y_r) * W_C + ADDR_W'(x_r);
      end else begin
        job_valid_r <= job_valid_r;
      end
    end else begin
      job_valid_r <= '0;
    end
  end

  // Result arbitration onto the frame-buffer write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_ack_r <= '0;
      res_rr_r  <= '0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= 8'd0;
      wr_cnt_r  <= '0;
    end else if (arb_en_s && arb_pick_s[IDX_W]) begin
      res_ack_r <= arb_oh_s;
      res_rr_r  <= idx_inc(arb_pick_s[IDX_W-1:0]);
      wr_en_r   <= 1'b1;
      wr_addr_r <= sel_addr_s;
      wr_data_r <= sel_iter_s;
      wr_cnt_r  <= wr_cnt_r + 1'b1;
    end else begin
      res_ack_r <= '0;
      wr_en_r   <= 1'b0;
      if (state_r == ST_SETUP) wr_cnt_r <= '0;
      else                     wr_cnt_r <= wr_cnt_r;
    end
  end

  // Rerun request and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      if (state_r == ST_DONE)                 pending_r <= 1'b0;
      else if (start && (state_r != ST_IDLE)) pending_r <= 1'b1;
      else                                    pending_r <= pending_r;
      busy_r <= busy_next_s;
      done_r <= done_next_s;
    end
  end

endmodule

// File: tb/tb_mandelbrot_core_scheduler.sv
module tb_mandelbrot_core_scheduler;

  logic               clk = 1'b0;
  logic               rst_n, start;
  logic signed [31:0] center_re, center_im, scale;
  logic [7:0]         max_iter;
  logic [3:0]         job_valid, job_ready, res_valid, res_ack;
  logic signed [31:0] job_re, job_im;
  logic [7:0]         job_addr, job_max_iter, wr_addr, wr_data;
  logic [31:0]        res_iter, res_addr;
  logic               wr_en, busy, done;

  mandelbrot_core_scheduler #(.W(4), .H(2), .ADDR_W(8), .CORE_NUM(4), .FP_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .center_re(center_re), .center_im(center_im), .scale(scale), .max_iter(max_iter),
    .job_valid(job_valid), .job_ready(job_ready), .job_re(job_re), .job_im(job_im),
    .job_addr(job_addr), .job_max_iter(job_max_iter),
    .res_valid(res_valid), .res_iter(res_iter), .res_addr(res_addr), .res_ack(res_ack),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Hand-computed per-address expectations: scale 1.0, centre 0, 4x2 grid.
  int exp_re [8] = '{-131072, -65536, 0, 65536, -131072, -65536, 0, 65536};
  int exp_im [8] = '{65536, 65536, 65536, 65536, 0, 0, 0, 0};
  int exp_dat[8] = '{3, 10, 17, 24, 31, 38, 45, 52};

  // Core model: fixed 3-cycle latency, iter = addr*7+3, results held while 'hold'.
  logic [3:0] ready_en, core_busy, res_pend;
  logic       hold;
  int         core_cnt [4];
  logic [7:0] core_addr[4];

  assign job_ready = ready_en & ~core_busy;
  assign res_valid = res_pend & ~{4{hold}};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_busy <= 4'h0;
      res_pend  <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        core_cnt[i]  <= 0;
        core_addr[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (job_valid[i] && job_ready[i]) begin
          core_busy[i] <= 1'b1;
          core_addr[i] <= job_addr;
          core_cnt[i]  <= 3;
        end else if (core_cnt[i] != 0) begin
          core_cnt[i] <= core_cnt[i] - 1;
          if (core_cnt[i] == 1) res_pend[i] <= 1'b1;
        end
        if (res_ack[i]) begin
          res_pend[i]  <= 1'b0;
          core_busy[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    res_iter = 32'h0;
    res_addr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      res_iter[i*8 +: 8] = core_addr[i] * 8'd7 + 8'd3;
      res_addr[i*8 +: 8] = core_addr[i];
    end
  end

  // Transaction monitor, sampled on the falling edge
  int n_disp = 0, n_wr = 0, n_ack = 0, n_done = 0, cyc = 0;
  int disp_addr[128], disp_core[128], disp_re[128], disp_im[128], disp_mi[128];
  int wr_a[128], wr_d[128], ack_v[128], ack_cyc[128];
  int busy_after_done[16];
  int wr_at_done = 0, busy_at_done = 0;
  logic prev_done = 1'b0;

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (|(job_valid & job_ready) && n_disp < 128) begin
      disp_addr[n_disp] = int'(job_addr);
      disp_core[n_disp] = oh_idx(job_valid & job_ready);
      disp_re[n_disp]   = job_re;
      disp_im[n_disp]   = job_im;
      disp_mi[n_disp]   = int'(job_max_iter);
      n_disp = n_disp + 1;
    end
    if (wr_en && n_wr < 128) begin
      wr_a[n_wr] = int'(wr_addr);
      wr_d[n_wr] = int'(wr_data);
      n_wr = n_wr + 1;
    end
    if (res_ack != 4'h0 && n_ack < 128) begin
      ack_v[n_ack]   = int'(res_ack);
      ack_cyc[n_ack] = cyc;
      n_ack = n_ack + 1;
    end
    if (prev_done && n_done > 0 && n_done <= 16) busy_after_done[n_done-1] = int'(busy);
    if (done) begin
      n_done       = n_done + 1;
      wr_at_done   = n_wr;
      busy_at_done = int'(busy);
    end
    prev_done = done;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int i = 0;
    while (n_done < target && i < budget) begin @(negedge clk); i++; end
    chk("done_within_budget", 64'(n_done >= target), 64'd1);
  endtask

  task automatic wait_disp(input int target, input int budget);
    int i = 0;
    while (n_disp < target && i < budget) begin @(negedge clk); i++; end
    chk("dispatch_within_budget", 64'(n_disp >= target), 64'd1);
  endtask

  // mode 1: cores round-robin 0,1,2,3; mode 2: all on core 2; else cores unchecked
  task automatic check_jobs(input int b, input int mode, input string tag);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_addr%0d", tag, k), disp_addr[b+k], k);
      chk($sformatf("%s_re%0d", tag, k), disp_re[b+k], exp_re[k]);
      chk($sformatf("%s_im%0d", tag, k), disp_im[b+k], exp_im[k]);
      chk($sformatf("%s_maxit%0d", tag, k), disp_mi[b+k], 50);
      if (mode == 1)      chk($sformatf("%s_core%0d", tag, k), disp_core[b+k], k % 4);
      else if (mode == 2) chk($sformatf("%s_core%0d", tag, k), disp_core[b+k], 2);
    end
  endtask

  task automatic check_writes(input int bw, input string tag);
    logic [7:0] seen = 8'h00;
    for (int k = 0; k < 8; k++) begin
      seen[wr_a[bw+k] & 7] = 1'b1;
      chk($sformatf("%s_wdata%0d", tag, k), wr_d[bw+k], exp_dat[wr_a[bw+k] & 7]);
      chk($sformatf("%s_waddr_range%0d", tag, k), 64'(wr_a[bw+k] < 8), 64'd1);
    end
    chk({tag, "_addr_coverage"}, seen, 8'hFF);
  endtask

  int b, bw, bd, na;

  initial begin
    rst_n = 1'b0; start = 1'b0; center_re = 0; center_im = 0; scale = 0;
    max_iter = 8'd0; ready_en = 4'h0; hold = 1'b0;
    #12;
    chk("rst_job_valid", job_valid, 0);
    chk("rst_res_ack", res_ack, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_job_addr", job_addr, 0);
    chk("rst_job_max_iter", job_max_iter, 0);
    @(negedge clk) rst_n = 1'b1;
    scale = 32'h0001_0000; max_iter = 8'd50; ready_en = 4'hF;

    // Frame 1: all cores ready; later centre change must not leak into the frame
    b = n_disp; bw = n_wr; bd = n_done;
    pulse_start();
    chk("f1_busy_after_start", busy, 1);
    center_re = 32'sh1234_5678;
    wait_done(bd + 1, 300);
    repeat (5) @(negedge clk);
    chk("f1_job_count", n_disp - b, 8);
    check_jobs(b, 1, "f1");
    chk("f1_write_count", n_wr - bw, 8);
    check_writes(bw, "f1");
    chk("f1_writes_before_done", wr_at_done - bw, 8);
    chk("f1_busy_at_done", busy_at_done, 0);
    chk("f1_done_count", n_done - bd, 1);
    chk("f1_idle_busy", busy, 0);
    center_re = 0;

    // Frame 2: only core 2 ready
    ready_en = 4'b0100;
    b = n_disp; bw = n_wr; bd = n_done;
    pulse_start();
    wait_done(bd + 1, 400);
    repeat (3) @(negedge clk);
    chk("f2_job_count", n_disp - b, 8);
    check_jobs(b, 2, "f2");
    chk("f2_write_count", n_wr - bw, 8);
    check_writes(bw, "f2");

    // Frames 3+4: two starts mid-frame collapse into one rerun
    ready_en = 4'hF;
    b = n_disp; bw = n_wr; bd = n_done;
    pulse_start();
    repeat (5) @(negedge clk);
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    wait_done(bd + 2, 600);
    repeat (30) @(negedge clk);
    chk("ms_done_count", n_done - bd, 2);
    chk("ms_job_count", n_disp - b, 16);
    chk("ms_write_count", n_wr - bw, 16);
    check_jobs(b, 0, "ms_a");
    check_jobs(b + 8, 0, "ms_b");
    check_writes(bw, "ms_a");
    check_writes(bw + 8, "ms_b");
    chk("ms_busy_after_first_done", busy_after_done[bd], 1);
    chk("ms_busy_after_second_done", busy_after_done[bd+1], 0);

    // Reset in the middle of dispatch
    b = n_disp;
    pulse_start();
    wait_disp(b + 2, 100);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_job_valid", job_valid, 0);
    chk("mr_res_ack", res_ack, 0);
    chk("mr_wr_en", wr_en, 0);
    chk("mr_busy", busy, 0);
    chk("mr_job_re", job_re, 0);
    chk("mr_job_addr", job_addr, 0);
    chk("mr_wr_data", wr_data, 0);
    @(negedge clk) rst_n = 1'b1;

    // Post-reset frame: results held back, then all four released at once
    hold = 1'b1;
    b = n_disp; bw = n_wr; bd = n_done; na = n_ack;
    pulse_start();
    wait_disp(b + 4, 100);
    repeat (6) @(negedge clk);
    chk("hold_job_count", n_disp - b, 4);
    chk("hold_no_ack", n_ack - na, 0);
    @(negedge clk) hold = 1'b0;
    wait_done(bd + 1, 300);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("hold_ack%0d", k), ack_v[na+k], 1 << k);
      chk($sformatf("hold_ack_gap%0d", k), ack_cyc[na+k] - ack_cyc[na], k);
      chk($sformatf("hold_core%0d", k), disp_core[b+k], k);
    end
    chk("pr_job_count", n_disp - b, 8);
    check_jobs(b, 0, "pr");
    chk("pr_write_count", n_wr - bw, 8);
    check_writes(bw, "pr");
    chk("pr_done_count", n_done - bd, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
